// File: rtl/demux_pkg.sv
// Shared constants and helpers for the parametrised lane demultiplexer.
package demux_pkg;

    localparam int MODE_RR   = 0;
    localparam int MODE_ADDR = 1;

    // Lane-index width; a single lane still needs a 1-bit select.
    function automatic int lane_w(input int lanes);
        return (lanes <= 1) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/demux_lane_ctr.sv
// Modulo-LANES lane pointer for round-robin distribution.
module demux_lane_ctr
    import demux_pkg::*;
#(
    parameter  int LANES = 4,
    localparam int LW    = lane_w(LANES)
) (
    input  logic          clk_f,
    input  logic          reset,
    input  logic          advance,
    input  logic          force_zero,
    output logic [LW-1:0] ptr
);

    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    logic [LW-1:0] ptr_q;
    logic [LW-1:0] ptr_d;
    logic [LW-1:0] base;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        base  = force_zero ? '0 : ptr_q;
        ptr_d = ptr_q;
        if (advance) begin
            // Explicit wrap: LANES need not be a power of two.
            ptr_d = (base == LAST) ? '0 : base + 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/demux_lanes_param.sv
// 1-to-LANES word demultiplexer: round-robin with frame realignment and optional
// aligned group release, or explicit lane addressing. All outputs registered.
module demux_lanes_param
    import demux_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int LANES   = 4,
    parameter  int MODE    = 0,
    parameter  int ALIGNED = 1,
    localparam int LW      = lane_w(LANES)
) (
    input  logic                   clk_f,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   valid_in,
    input  logic                   sof_in,
    input  logic [LW-1:0]          sel_in,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   group_done,
    output logic                   err_partial
);

    localparam bit              STAGED  = (MODE == MODE_RR) && (ALIGNED != 0);
    localparam logic [LW-1:0]   LAST    = LW'(LANES - 1);
    localparam logic [LW:0]     LANES_X = (LW + 1)'(LANES);

    logic [LW-1:0]    target;
    logic             discard;
    logic             drop;
    logic             wr_en;
    logic             is_last;
    logic             group_d;
    logic             err_d;
    logic [LANES-1:0] valid_out_d;

    logic [LANES-1:0] valid_out_q;
    logic             group_done_q;
    logic             err_q;

    if (MODE == MODE_RR) begin : g_rr
        logic [LW-1:0] ptr;
        // sel_in carries no meaning in round-robin distribution.
        logic          unused_sel;

        demux_lane_ctr #(.LANES(LANES)) u_ctr (
            .clk_f      (clk_f),
            .reset      (reset),
            .advance    (valid_in),
            .force_zero (sof_in),
            .ptr        (ptr)
        );

        assign target     = sof_in ? '0 : ptr;
        // A frame restart mid-group throws away what was staged.
        assign discard    = STAGED && valid_in && sof_in && (ptr != '0);
        assign drop       = 1'b0;
        assign unused_sel = ^sel_in;
    end else begin : g_addr
        logic unused_sof;

        assign target     = sel_in;
        assign discard    = 1'b0;
        assign drop       = valid_in && ({1'b0, sel_in} >= LANES_X);
        assign unused_sof = sof_in;
    end

    assign wr_en   = valid_in && !drop;
    assign is_last = (target == LAST);
    assign group_d = (MODE == MODE_RR) && wr_en && is_last && !discard;
    assign err_d   = discard || drop;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [LW-1:0] K = LW'(k);

        logic             hit;
        logic [WIDTH-1:0] lane_q;

        assign hit = wr_en && (target == K);

        if (STAGED && (k < LANES - 1)) begin : g_stage
            logic [WIDTH-1:0] stage_q;

            // NOTE: staging and lane registers are reset too, so a reset mid-group
            // leaves no stale word that could surface in a later release.
            always_ff @(posedge clk_f or negedge reset) begin
                if (!reset) begin
                    stage_q <= '0;
                    lane_q  <= '0;
                end else begin
                    if (hit) begin
                        stage_q <= data_in;
                    end
                    if (group_d) begin
                        lane_q <= stage_q;
                    end
                end
            end
        end else if (STAGED) begin : g_last
            // The closing word goes straight to its lane alongside the staged ones.
            always_ff @(posedge clk_f or negedge reset) begin
                if (!reset) begin
                    lane_q <= '0;
                end else if (group_d) begin
                    lane_q <= data_in;
                end
            end
        end else begin : g_direct
            always_ff @(posedge clk_f or negedge reset) begin
                if (!reset) begin
                    lane_q <= '0;
                end else if (hit) begin
                    lane_q <= data_in;
                end
            end
        end

        assign valid_out_d[k]               = STAGED ? group_d : hit;
        assign data_out[k*WIDTH +: WIDTH]   = lane_q;
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            valid_out_q  <= '0;
            group_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            valid_out_q  <= valid_out_d;
            group_done_q <= group_d;
            err_q        <= err_d;
        end
    end

    assign valid_out   = valid_out_q;
    assign group_done  = group_done_q;
    assign err_partial = err_q;

endmodule

// File: tb/tb_demux_lanes_param.sv
// Directed bench for demux_lanes_param in three configurations: aligned round-robin,
// per-lane round-robin over three lanes, and addressed mode over three lanes.
module tb_demux_lanes_param;

    logic clk_f = 1'b0;
    logic reset = 1'b0;

    always #5 clk_f = ~clk_f;

    // Instance A: MODE 0, ALIGNED 1, LANES 4, WIDTH 8
    logic [7:0]  a_data  = '0;
    logic        a_valid = 1'b0;
    logic        a_sof   = 1'b0;
    logic [1:0]  a_sel   = '0;
    logic [31:0] a_dout;
    logic [3:0]  a_vout;
    logic        a_gd;
    logic        a_err;

    // Instance B: MODE 0, ALIGNED 0, LANES 3
    logic [7:0]  b_data  = '0;
    logic        b_valid = 1'b0;
    logic        b_sof   = 1'b0;
    logic [1:0]  b_sel   = '0;
    logic [23:0] b_dout;
    logic [2:0]  b_vout;
    logic        b_gd;
    logic        b_err;

    // Instance C: MODE 1, LANES 3
    logic [7:0]  c_data  = '0;
    logic        c_valid = 1'b0;
    logic        c_sof   = 1'b0;
    logic [1:0]  c_sel   = '0;
    logic [23:0] c_dout;
    logic [2:0]  c_vout;
    logic        c_gd;
    logic        c_err;

    int checks   = 0;
    int failures = 0;

    demux_lanes_param #(.WIDTH(8), .LANES(4), .MODE(0), .ALIGNED(1)) u_a (
        .clk_f(clk_f), .reset(reset), .data_in(a_data), .valid_in(a_valid),
        .sof_in(a_sof), .sel_in(a_sel), .data_out(a_dout), .valid_out(a_vout),
        .group_done(a_gd), .err_partial(a_err)
    );

    demux_lanes_param #(.WIDTH(8), .LANES(3), .MODE(0), .ALIGNED(0)) u_b (
        .clk_f(clk_f), .reset(reset), .data_in(b_data), .valid_in(b_valid),
        .sof_in(b_sof), .sel_in(b_sel), .data_out(b_dout), .valid_out(b_vout),
        .group_done(b_gd), .err_partial(b_err)
    );

    demux_lanes_param #(.WIDTH(8), .LANES(3), .MODE(1), .ALIGNED(1)) u_c (
        .clk_f(clk_f), .reset(reset), .data_in(c_data), .valid_in(c_valid),
        .sof_in(c_sof), .sel_in(c_sel), .data_out(c_dout), .valid_out(c_vout),
        .group_done(c_gd), .err_partial(c_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word, let the edge take it, sample 1 time unit later.
    task automatic step_a(input logic v, input logic s, input logic [7:0] d);
        a_valid = v;
        a_sof   = s;
        a_data  = d;
        @(posedge clk_f);
        #1;
    endtask

    task automatic step_b(input logic v, input logic [7:0] d);
        b_valid = v;
        b_data  = d;
        @(posedge clk_f);
        #1;
    endtask

    task automatic step_c(input logic v, input logic [1:0] s, input logic [7:0] d);
        c_valid = v;
        c_sel   = s;
        c_data  = d;
        @(posedge clk_f);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_f);
        #1;
        check("rst_a_dout", a_dout, 32'h0);
        check("rst_a_vout", {28'h0, a_vout}, 32'h0);
        check("rst_a_gd_err", {30'h0, a_gd, a_err}, 32'h0);
        check("rst_c_vout", {29'h0, c_vout}, 32'h0);
        reset = 1'b1;

        // Back-to-back aligned group
        step_a(1'b1, 1'b0, 8'h00);
        check("g1_w0_vout", {28'h0, a_vout}, 32'h0);
        step_a(1'b1, 1'b0, 8'h10);
        check("g1_w1_gd", {31'h0, a_gd}, 32'h0);
        step_a(1'b1, 1'b0, 8'h02);
        check("g1_w2_vout", {28'h0, a_vout}, 32'h0);
        step_a(1'b1, 1'b0, 8'hF0);
        check("g1_dout", a_dout, 32'hF002_1000);
        check("g1_vout", {28'h0, a_vout}, 32'hF);
        check("g1_gd_err", {30'h0, a_gd, a_err}, 32'h2);
        step_a(1'b0, 1'b0, 8'h00);
        check("g1_idle_strobes", {26'h0, a_vout, a_gd, a_err}, 32'h0);
        check("g1_idle_hold", a_dout, 32'hF002_1000);

        // Frame restart mid-group
        step_a(1'b1, 1'b0, 8'h00);
        step_a(1'b1, 1'b0, 8'h10);
        step_a(1'b1, 1'b1, 8'hAC);
        check("g2_sof_err", {31'h0, a_err}, 32'h1);
        check("g2_sof_vout", {28'h0, a_vout}, 32'h0);
        step_a(1'b1, 1'b0, 8'h29);
        check("g2_err_once", {31'h0, a_err}, 32'h0);
        step_a(1'b1, 1'b0, 8'hA8);
        step_a(1'b1, 1'b0, 8'hF9);
        check("g2_dout", a_dout, 32'hF9A8_29AC);
        check("g2_gd", {31'h0, a_gd}, 32'h1);

        // sof while ptr = LANES-1 discards rather than completes
        step_a(1'b1, 1'b0, 8'h01);
        step_a(1'b1, 1'b0, 8'h02);
        step_a(1'b1, 1'b0, 8'h03);
        step_a(1'b1, 1'b1, 8'h55);
        check("g3_lastsof_err_gd", {30'h0, a_gd, a_err}, 32'h1);
        check("g3_lastsof_vout", {28'h0, a_vout}, 32'h0);
        step_a(1'b1, 1'b0, 8'h66);
        step_a(1'b1, 1'b0, 8'h77);
        step_a(1'b1, 1'b0, 8'h88);
        check("g3_dout", a_dout, 32'h8877_6655);

        // sof at ptr = 0 is clean
        step_a(1'b1, 1'b1, 8'h99);
        check("g4_sof0_err", {31'h0, a_err}, 32'h0);
        step_a(1'b1, 1'b0, 8'hAA);
        step_a(1'b1, 1'b0, 8'hBB);
        step_a(1'b1, 1'b0, 8'hCC);
        check("g4_dout", a_dout, 32'hCCBB_AA99);

        // Gapped valid: pointer holds across idle cycles
        step_a(1'b1, 1'b0, 8'h11);
        check("g5_w0_gd", {31'h0, a_gd}, 32'h0);
        step_a(1'b0, 1'b1, 8'hEE);
        check("g5_gap1_gd_err", {30'h0, a_gd, a_err}, 32'h0);
        step_a(1'b0, 1'b0, 8'hEE);
        check("g5_gap2_vout", {28'h0, a_vout}, 32'h0);
        step_a(1'b1, 1'b0, 8'h22);
        step_a(1'b1, 1'b0, 8'h33);
        check("g5_w2_gd", {31'h0, a_gd}, 32'h0);
        step_a(1'b1, 1'b0, 8'h44);
        check("g5_dout", a_dout, 32'h4433_2211);
        check("g5_gd", {31'h0, a_gd}, 32'h1);
        step_a(1'b0, 1'b0, 8'h00);

        // Per-lane release over three lanes
        step_b(1'b1, 8'h75);
        check("b_w0_vout", {29'h0, b_vout}, 32'h1);
        check("b_w0_lane0", {24'h0, b_dout[7:0]}, 32'h75);
        step_b(1'b1, 8'h43);
        check("b_w1_vout", {29'h0, b_vout}, 32'h2);
        check("b_w1_gd", {31'h0, b_gd}, 32'h0);
        step_b(1'b1, 8'hF9);
        check("b_w2_vout", {29'h0, b_vout}, 32'h4);
        check("b_w2_gd", {31'h0, b_gd}, 32'h1);
        step_b(1'b1, 8'h01);
        check("b_w3_vout", {29'h0, b_vout}, 32'h1);
        check("b_w3_gd", {31'h0, b_gd}, 32'h0);
        check("b_dout", {8'h0, b_dout}, 32'h00F9_4301);
        step_b(1'b0, 8'h00);
        check("b_idle_vout", {29'h0, b_vout}, 32'h0);

        // Addressed mode
        step_c(1'b1, 2'd2, 8'hDB);
        check("c_sel2_vout", {29'h0, c_vout}, 32'h4);
        check("c_sel2_dout", {8'h0, c_dout}, 32'h00DB_0000);
        check("c_sel2_err", {31'h0, c_err}, 32'h0);
        step_c(1'b1, 2'd3, 8'h29);
        check("c_sel3_err", {31'h0, c_err}, 32'h1);
        check("c_sel3_vout", {29'h0, c_vout}, 32'h0);
        check("c_sel3_hold", {8'h0, c_dout}, 32'h00DB_0000);
        step_c(1'b1, 2'd0, 8'h5A);
        check("c_sel0_vout_gd", {28'h0, c_vout, c_gd}, 32'h2);
        check("c_sel0_dout", {8'h0, c_dout}, 32'h00DB_005A);
        step_c(1'b0, 2'd0, 8'h00);

        // Asynchronous reset with two words staged
        step_a(1'b1, 1'b0, 8'h01);
        step_a(1'b1, 1'b0, 8'h02);
        a_valid = 1'b0;
        @(posedge clk_f);
        #3;
        reset = 1'b0;
        #1;
        check("arst_a_dout", a_dout, 32'h0);
        check("arst_a_flags", {26'h0, a_vout, a_gd, a_err}, 32'h0);
        check("arst_b_dout", {8'h0, b_dout}, 32'h0);
        check("arst_c_dout", {8'h0, c_dout}, 32'h0);
        @(posedge clk_f);
        #1;
        reset = 1'b1;
        step_a(1'b1, 1'b0, 8'hD0);
        check("post_rst_err", {31'h0, a_err}, 32'h0);
        step_a(1'b1, 1'b0, 8'hD1);
        step_a(1'b1, 1'b0, 8'hD2);
        check("post_rst_early_gd", {31'h0, a_gd}, 32'h0);
        step_a(1'b1, 1'b0, 8'hD3);
        check("post_rst_dout", a_dout, 32'hD3D2_D1D0);
        check("post_rst_gd_vout", {27'h0, a_vout, a_gd}, 32'h1F);
        step_a(1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_lanes_param.md
# demux_lanes_param

Parametrised 1-to-N byte demultiplexer for the receive path. It sits after the serial-to-parallel stage and distributes a single valid-qualified data stream across `LANES` output lanes. Two distribution modes are supported: round-robin with frame realignment, or explicit lane addressing. An optional aligned release presents all lanes of a group in the same cycle. It extends the fixed 4-lane, 8-bit demux in width, lane count, mode and error reporting.

## Interface
- `WIDTH`, 8, data width per lane in bits (≥1)
- `LANES`, 4, number of output lanes (≥1; need not be a power of two)
- `MODE`, 0, distribution mode: 0 = round-robin, 1 = addressed by `sel_in`
- `ALIGNED`, 1, lane release in `MODE` 0: 1 = release the whole group at once, 0 = per-lane immediate release; ignored when `MODE`=1
- `clk_f`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `data_in`  in  `WIDTH`  input word
- `valid_in`  in  1  qualifies `data_in`, `sof_in` and `sel_in`
- `sof_in`  in  1  start of frame; forces the current word to lane 0 (`MODE` 0 only)
- `sel_in`  in  `LW`  target lane in `MODE` 1, where `LW` = max(1, clog2(`LANES`))
- `data_out`  out  `LANES*WIDTH`  lane k occupies bits [k*WIDTH +: WIDTH]
- `valid_out`  out  `LANES`  per-lane one-cycle valid strobe
- `group_done`  out  1  one-cycle pulse when a full group is released
- `err_partial`  out  1  one-cycle pulse when an incomplete group is discarded or a word is dropped

## Operation
- Internal lane pointer `ptr` has range 0..`LANES`-1 and wraps from `LANES`-1 to 0 (modulo `LANES`, not binary wrap).
- When `valid_in`=0, nothing changes: `ptr` holds and `sof_in`/`sel_in` are ignored. All strobes are 0 the following cycle.

**`MODE` 0**
- Target lane = 0 if `sof_in`=1, otherwise `ptr`.
- After the write, `ptr` ← (target+1) mod `LANES`.

**`MODE` 0, `ALIGNED`=0**
- The lane register is loaded with the word.
- `valid_out[target]` pulses.
- `group_done` pulses when target=`LANES`-1.

**`MODE` 0, `ALIGNED`=1**
- Words for lanes 0..`LANES`-2 go to staging registers.
- A write to lane `LANES`-1 transfers all staged words plus the current word into `data_out`. In that output cycle, `valid_out` is all ones and `group_done`=1.
- If `sof_in`=1 arrives while `ptr`≠0, the staged partial group is discarded and `err_partial` pulses. The new word is then staged as lane 0.

**`MODE` 1**
- Target lane = `sel_in`.
- The lane register is loaded and `valid_out[sel_in]` pulses. `group_done` stays 0.
- If `sel_in` ≥ `LANES`, the word is dropped and `err_partial` pulses.

**General**
- `data_out` lanes hold their last value when not strobed.
- With `LANES`=1, every valid word completes a group.

## Timing
- Reset (asynchronous assert, release sampled at `clk_f`) clears: `ptr`, staging, `data_out`=0, `valid_out`=0, `group_done`=0, `err_partial`=0.
- Reset mid-group loses the staged words with no `err_partial`.
- Latency: 1 cycle from the `clk_f` edge that samples `valid_in`=1 to the output strobe. All outputs are registered.
- Throughput: one word per cycle, back-to-back. No stall or backpressure exists.
- Simultaneous `sof_in` with `ptr`=`LANES`-1 in `ALIGNED`=1 mode: this is a discard plus error, not a completion.
- `sof_in`=1 when `ptr`=0: no error.

## Structure
- Package `demux_pkg` holds:
  - `MODE_RR`=0 and `MODE_ADDR`=1 constants
  - function `lane_w(LANES)` returning max(1, clog2)
- Sub-module `demux_lane_ctr` is the modulo-`LANES` pointer. Inputs: `clk_f`, `reset`, advance, force-zero. Output: `ptr`.
- Top level contains the staging array, lane registers and strobe logic, using generate loops over `LANES`.

## Test plan
- `MODE`0, `ALIGNED`=1, `LANES`=4, `WIDTH`=8; stream 00,10,02,F0 back-to-back → one cycle after F0, `data_out`=F0_02_10_00, `valid_out`=4'hF, `group_done`=1; strobes are quiet on the other cycles.
- Same configuration; send 00,10 then `sof_in` with AC, then 29,A8,F9 → `err_partial` pulses once; next group released is F9_A8_29_AC.
- `MODE`0, `ALIGNED`=0, `LANES`=3; send 75,43,F9,01 → `valid_out` sequence 001,010,100,001; `group_done` after F9; lane 0 holds 01.
- `MODE`1, `LANES`=3; `sel_in`=2 with DB, then `sel_in`=3 with 29 → `valid_out`=100 with lane 2=DB; then `err_partial`=1 and `valid_out`=0.
- Gapped `valid_in` (1,0,0,1,1,1) with `ALIGNED`=1 → a single `group_done`, and `ptr` holds across the gaps.
- Assert `reset`=0 asynchronously after two staged words → all outputs 0 immediately; after release, the next 4 words form a clean group.
